// File: rtl/padded_ifm_reader.sv
// padded_ifm_reader
// Streams a padded feature map out of the line/feature buffer in sliding-window
// order (KxK, stride 1 or 2), one PE-wide channel word per beat. Reads are held
// back until the padding writer has finished the rows they need. A 2-entry
// output buffer absorbs the one-cycle RAM read latency under backpressure.

module padded_ifm_reader #(
   parameter int PE        = 16,
   parameter int K         = 3,
   parameter int ADDR_STEP = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        IFM_C,
   input  logic [7:0]        IFM_W,
   input  logic              padding,
   input  logic [1:0]        stride,
   input  logic              row_done,
   output logic              rd_en,
   output logic [31:0]       rd_addr,
   input  logic [PE*8-1:0]   rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PE*8-1:0]   out_data,
   output logic              out_last_win,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int          DW    = PE * 8;
   localparam logic [31:0] KW    = 32'(K);
   localparam logic [31:0] PEW   = 32'(PE);
   localparam logic [31:0] STEPW = 32'(ADDR_STEP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t r_state;
   state_t w_nextState;

   // Map geometry captured when a map is accepted
   logic [31:0] r_cw;
   logic [31:0] r_wp;
   logic [31:0] r_ow;
   logic        r_stride2;

   // Padded rows the writer has completed for the current map
   logic [31:0] r_rows;

   // Loop counters, innermost first: c, kx, ky, ox, oy
   logic [31:0] r_c;
   logic [31:0] r_kx;
   logic [31:0] r_ky;
   logic [31:0] r_ox;
   logic [31:0] r_oy;

   // Read issued last cycle; its data and tags arrive this cycle
   logic r_pending;
   logic r_pendLastWin;
   logic r_pendLast;

   // Two-entry output buffer
   logic [DW-1:0] r_memData [2];
   logic [1:0]    r_memLastWin;
   logic [1:0]    r_memLast;
   logic          r_wrPtr;
   logic          r_rdPtr;
   logic [1:0]    r_count;

   logic r_done;

   logic        w_startAccept;
   logic [31:0] w_cwIn;
   logic [31:0] w_wpIn;
   logic [31:0] w_owIn;
   logic [31:0] w_row;
   logic [31:0] w_col;
   logic        w_lastWin;
   logic        w_lastAll;
   logic        w_outValid;
   logic        w_pop;
   logic        w_headLast;
   logic [2:0]  w_credits;
   logic        w_creditOk;
   logic        w_rowReady;
   logic        w_issue;
   logic        w_doneSet;

   assign w_startAccept = start && (r_state == IDLE);

   // Geometry derived straight from the config inputs so it is ready in LOAD.
   // Stride 2 halves the span with a shift; any other stride code acts as 1.
   assign w_cwIn = {24'd0, IFM_C} / PEW;
   assign w_wpIn = {24'd0, IFM_W} + (padding ? 32'd2 : 32'd0);
   assign w_owIn = (w_wpIn < KW) ? 32'd0 :
                   (((stride == 2'd2) ? ((w_wpIn - KW) >> 1) : (w_wpIn - KW)) + 32'd1);

   // Buffer coordinates of the word the counters point at
   assign w_row   = (r_stride2 ? (r_oy << 1) : r_oy) + r_ky;
   assign w_col   = (r_stride2 ? (r_ox << 1) : r_ox) + r_kx;
   assign rd_addr = ((w_row * r_wp + w_col) * r_cw + r_c) * STEPW;

   assign w_lastWin = (r_c == r_cw - 32'd1) && (r_kx == KW - 32'd1) && (r_ky == KW - 32'd1);
   assign w_lastAll = w_lastWin && (r_ox == r_ow - 32'd1) && (r_oy == r_ow - 32'd1);

   assign w_outValid = (r_count != 2'd0);
   assign w_pop      = w_outValid && out_ready;
   assign w_headLast = r_memLast[r_rdPtr];

   // The slot freed by a pop in this cycle counts as available, which is what
   // lets a 2-entry buffer sustain one word per cycle with one read in flight.
   assign w_credits  = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
   assign w_creditOk = (w_credits < 3'd2);
   assign w_rowReady = (w_row < r_rows);

   assign rd_en        = w_issue;
   assign out_valid    = w_outValid;
   assign out_data     = r_memData[r_rdPtr];
   assign out_last_win = w_outValid && r_memLastWin[r_rdPtr];
   assign out_last     = w_outValid && r_memLast[r_rdPtr];
   assign busy         = (r_state != IDLE);
   assign done         = r_done;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state, read issue and completion decisions
   always_comb begin
      w_nextState = r_state;
      w_issue     = 1'b0;
      w_doneSet   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = LOAD;
            end
         end
         LOAD: begin
            if ((r_cw == 32'd0) || (r_wp < KW)) begin
               w_nextState = IDLE;
               w_doneSet   = 1'b1;
            end else begin
               w_nextState = READ;
            end
         end
         READ: begin
            if (w_rowReady && w_creditOk) begin
               w_issue = 1'b1;
               if (w_lastAll) begin
                  w_nextState = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (w_pop && w_headLast) begin
               w_nextState = IDLE;
               w_doneSet   = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Capture map geometry when a map is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cw      <= '0;
         r_wp      <= '0;
         r_ow      <= '0;
         r_stride2 <= 1'b0;
      end else if (w_startAccept) begin
         r_cw      <= w_cwIn;
         r_wp      <= w_wpIn;
         r_ow      <= w_owIn;
         r_stride2 <= (stride == 2'd2);
      end
   end

   // Count completed rows; a row_done coinciding with start belongs to the new map
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rows <= '0;
      end else if (w_startAccept) begin
         r_rows <= row_done ? 32'd1 : 32'd0;
      end else if (row_done && (r_rows < r_wp)) begin
         r_rows <= r_rows + 32'd1;
      end
   end

   // Walk c, kx, ky, ox, oy once per issued read; everything wraps to zero after the last
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c  <= '0;
         r_kx <= '0;
         r_ky <= '0;
         r_ox <= '0;
         r_oy <= '0;
      end else if (w_startAccept) begin
         r_c  <= '0;
         r_kx <= '0;
         r_ky <= '0;
         r_ox <= '0;
         r_oy <= '0;
      end else if (w_issue) begin
         if (r_c == r_cw - 32'd1) begin
            r_c <= '0;
            if (r_kx == KW - 32'd1) begin
               r_kx <= '0;
               if (r_ky == KW - 32'd1) begin
                  r_ky <= '0;
                  if (r_ox == r_ow - 32'd1) begin
                     r_ox <= '0;
                     if (r_oy == r_ow - 32'd1) begin
                        r_oy <= '0;
                     end else begin
                        r_oy <= r_oy + 32'd1;
                     end
                  end else begin
                     r_ox <= r_ox + 32'd1;
                  end
               end else begin
                  r_ky <= r_ky + 32'd1;
               end
            end else begin
               r_kx <= r_kx + 32'd1;
            end
         end else begin
            r_c <= r_c + 32'd1;
         end
      end
   end

   // Remember which issued read returns next cycle, with its window/map tags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending     <= 1'b0;
         r_pendLastWin <= 1'b0;
         r_pendLast    <= 1'b0;
      end else begin
         r_pending     <= w_issue;
         r_pendLastWin <= w_issue && w_lastWin;
         r_pendLast    <= w_issue && w_lastAll;
      end
   end

   // Output buffer: push returning read data, pop on accepted beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_memData[0] <= '0;
         r_memData[1] <= '0;
         r_memLastWin <= '0;
         r_memLast    <= '0;
         r_wrPtr      <= 1'b0;
         r_rdPtr      <= 1'b0;
         r_count      <= '0;
      end else begin
         if (r_pending) begin
            r_memData[r_wrPtr]    <= rd_data;
            r_memLastWin[r_wrPtr] <= r_pendLastWin;
            r_memLast[r_wrPtr]    <= r_pendLast;
            r_wrPtr               <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         r_count <= r_count + {1'b0, r_pending} - {1'b0, w_pop};
      end
   end

   // One-cycle completion pulse, raised as the FSM returns to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
      end else begin
         r_done <= w_doneSet;
      end
   end

endmodule

// File: tb/tb_padded_ifm_reader.sv
// tb_padded_ifm_reader
// Directed bench for padded_ifm_reader: drives configurations and row_done
// pulses, models the buffer RAM, logs reads and beats, and checks them
// against hand-computed and formula-derived expectations.

module tb_padded_ifm_reader;

   localparam int PE        = 16;
   localparam int K         = 3;
   localparam int ADDR_STEP = 4;
   localparam int DW        = PE * 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [7:0]    IFM_C;
   logic [7:0]    IFM_W;
   logic          padding;
   logic [1:0]    stride;
   logic          row_done;
   logic          rd_en;
   logic [31:0]   rd_addr;
   logic [DW-1:0] rd_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last_win;
   logic          out_last;
   logic          busy;
   logic          done;

   int nAsserts = 0;
   int nFails   = 0;
   int cycle    = 0;

   logic [31:0]   rdAddrQ [$];
   int            rdCycleQ [$];
   logic [DW-1:0] beatDataQ [$];
   logic          beatWinQ [$];
   logic          beatLastQ [$];
   int            beatCycleQ [$];
   int            doneCycleQ [$];
   logic          doneBusyQ [$];
   logic [31:0]   expAddrQ [$];

   int            stallErr = 0;
   int            rdTot = 0;
   int            beatTot = 0;
   int            maxOutstanding = 0;
   logic          prevStall = 1'b0;
   logic [DW-1:0] prevData = '0;
   logic          prevWin = 1'b0;
   logic          prevLast = 1'b0;

   int rdBase;
   int beatBase;
   int doneBase;

   always #5 clk = ~clk;

   padded_ifm_reader #(
      .PE(PE),
      .K(K),
      .ADDR_STEP(ADDR_STEP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .IFM_C(IFM_C),
      .IFM_W(IFM_W),
      .padding(padding),
      .stride(stride),
      .row_done(row_done),
      .rd_en(rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_last_win(out_last_win),
      .out_last(out_last),
      .busy(busy),
      .done(done)
   );

   function automatic logic [DW-1:0] memWord(input logic [31:0] a);
      return {(DW/32){a ^ 32'h5A3C_0000}};
   endfunction

   // Buffer RAM: data for the address requested last cycle, junk otherwise
   always @(posedge clk) begin
      rd_data <= rd_en ? memWord(rd_addr) : {DW{1'b1}};
   end

   // Free-running cycle counter for latency bookkeeping
   always @(posedge clk) begin
      cycle <= cycle + 1;
   end

   // Log reads, beats and done pulses; watch stall stability and outstanding reads
   always @(negedge clk) begin
      if (rd_en) begin
         rdAddrQ.push_back(rd_addr);
         rdCycleQ.push_back(cycle);
      end
      if (out_valid && out_ready) begin
         beatDataQ.push_back(out_data);
         beatWinQ.push_back(out_last_win);
         beatLastQ.push_back(out_last);
         beatCycleQ.push_back(cycle);
      end
      if (done) begin
         doneCycleQ.push_back(cycle);
         doneBusyQ.push_back(busy);
      end
      if (!rst_n) begin
         rdTot     <= 0;
         beatTot   <= 0;
         prevStall <= 1'b0;
      end else begin
         if (prevStall && (!out_valid || out_data !== prevData ||
                           out_last_win !== prevWin || out_last !== prevLast)) begin
            stallErr <= stallErr + 1;
         end
         prevStall <= out_valid && !out_ready;
         prevData  <= out_data;
         prevWin   <= out_last_win;
         prevLast  <= out_last;
         rdTot     <= rdTot + int'(rd_en);
         beatTot   <= beatTot + int'(out_valid && out_ready);
         if (rdTot + int'(rd_en) - beatTot - int'(out_valid && out_ready) > maxOutstanding) begin
            maxOutstanding <= rdTot + int'(rd_en) - beatTot - int'(out_valid && out_ready);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic mark();
      rdBase   = rdAddrQ.size();
      beatBase = beatDataQ.size();
      doneBase = doneCycleQ.size();
   endtask

   // Drive a config with a one-cycle start; returns in the cycle after the start edge
   task automatic applyStimulus(input logic [7:0] c, input logic [7:0] w, input logic p,
                                input logic [1:0] s, input logic rowWithStart);
      IFM_C    = c;
      IFM_W    = w;
      padding  = p;
      stride   = s;
      start    = 1'b1;
      row_done = rowWithStart;
      tick();
      start    = 1'b0;
      row_done = 1'b0;
   endtask

   task automatic pulseRows(input int n);
      row_done = 1'b1;
      repeat (n) tick();
      row_done = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int maxCycles);
      int i = 0;
      while (doneCycleQ.size() <= doneBase && i < maxCycles) begin
         tick();
         i++;
      end
      checkVal({tag, "_done_seen"}, 32'(doneCycleQ.size() > doneBase), 32'd1);
   endtask

   // Address order from the closed-form window formula
   task automatic buildExpected(input int cw, input int wp, input int ow, input int s);
      expAddrQ.delete();
      for (int oy = 0; oy < ow; oy++)
         for (int ox = 0; ox < ow; ox++)
            for (int ky = 0; ky < K; ky++)
               for (int kx = 0; kx < K; kx++)
                  for (int c = 0; c < cw; c++)
                     expAddrQ.push_back(32'((((oy*s + ky) * wp + ox*s + kx) * cw + c) * ADDR_STEP));
   endtask

   task automatic checkStream(input string tag, input int nBeats, input int winLen);
      int nb = beatDataQ.size() - beatBase;
      int nr = rdAddrQ.size() - rdBase;
      checkVal({tag, "_beats"}, nb, nBeats);
      checkVal({tag, "_reads"}, nr, nBeats);
      for (int i = 0; i < nBeats && i < nr; i++)
         checkVal($sformatf("%s_addr%0d", tag, i), rdAddrQ[rdBase+i], expAddrQ[i]);
      for (int i = 0; i < nBeats && i < nb; i++) begin
         checkOutput($sformatf("%s_data%0d", tag, i), beatDataQ[beatBase+i], memWord(expAddrQ[i]));
         checkVal($sformatf("%s_win%0d", tag, i), 32'(beatWinQ[beatBase+i]), 32'(((i + 1) % winLen) == 0));
         checkVal($sformatf("%s_last%0d", tag, i), 32'(beatLastQ[beatBase+i]), 32'(i == nBeats - 1));
      end
      checkVal({tag, "_done_count"}, 32'(doneCycleQ.size() - doneBase), 32'd1);
      if (doneCycleQ.size() > doneBase && nb > 0) begin
         checkVal({tag, "_done_lat"}, doneCycleQ[doneBase], beatCycleQ[beatBase+nb-1] + 1);
         checkVal({tag, "_done_busy"}, 32'(doneBusyQ[doneBase]), 32'd0);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkVal({tag, "_rd_en"}, 32'(rd_en), 32'd0);
      checkVal({tag, "_rd_addr"}, rd_addr, 32'd0);
      checkVal({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_out_data"}, out_data, '0);
      checkVal({tag, "_last_win"}, 32'(out_last_win), 32'd0);
      checkVal({tag, "_last"}, 32'(out_last), 32'd0);
      checkVal({tag, "_busy"}, 32'(busy), 32'd0);
      checkVal({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // Directed sequence
   initial begin
      logic [31:0] firstWin [9];
      firstWin = '{32'd0, 32'd4, 32'd8, 32'd16, 32'd20, 32'd24, 32'd32, 32'd36, 32'd40};

      rst_n = 1'b0; start = 1'b0; IFM_C = '0; IFM_W = '0; padding = 1'b0;
      stride = '0; row_done = 1'b0; out_ready = 1'b1;
      rdBase = 0; beatBase = 0; doneBase = 0;
      repeat (3) tick();
      checkResetOutputs("rst");
      rst_n = 1'b1;
      tick();

      // C=16, W=2, pad 1, stride 1: CW=1, WP=4, OW=2, 36 beats
      mark();
      applyStimulus(8'd16, 8'd2, 1'b1, 2'd1, 1'b1);
      checkVal("c1_load_busy", 32'(busy), 32'd1);
      checkVal("c1_load_rd_en", 32'(rd_en), 32'd0);
      row_done = 1'b1;
      tick();
      checkVal("c1_first_rd_en", 32'(rd_en), 32'd1);
      checkVal("c1_first_addr", rd_addr, 32'd0);
      tick();
      tick();
      row_done = 1'b0;
      waitDone("c1", 200);
      for (int i = 0; i < 9 && rdBase + i < rdAddrQ.size(); i++)
         checkVal($sformatf("c1_win0_addr%0d", i), rdAddrQ[rdBase+i], firstWin[i]);
      buildExpected(1, 4, 2, 1);
      checkStream("c1", 36, 9);
      if (beatDataQ.size() - beatBase == 36 && rdAddrQ.size() - rdBase == 36) begin
         checkVal("c1_read_to_out", beatCycleQ[beatBase], rdCycleQ[rdBase] + 2);
         checkVal("c1_throughput", beatCycleQ[beatBase+35] - beatCycleQ[beatBase], 32'd35);
      end
      checkVal("c1_outstanding", 32'(maxOutstanding <= 2), 32'd1);

      // C=32, W=4, pad 1, stride 2: CW=2, WP=6, OW=2, 72 beats
      mark();
      applyStimulus(8'd32, 8'd4, 1'b1, 2'd2, 1'b1);
      pulseRows(5);
      waitDone("c2", 300);
      if (rdAddrQ.size() > rdBase)
         checkVal("c2_last_addr", rdAddrQ[rdAddrQ.size()-1], 32'd228);
      buildExpected(2, 6, 2, 2);
      checkStream("c2", 72, 18);

      // Only two rows available: six reads then stall until the third row
      mark();
      applyStimulus(8'd16, 8'd2, 1'b1, 2'd1, 1'b1);
      pulseRows(1);
      repeat (30) tick();
      checkVal("c3_gated_reads", 32'(rdAddrQ.size() - rdBase), 32'd6);
      for (int i = 0; i < 6 && rdBase + i < rdAddrQ.size(); i++)
         checkVal($sformatf("c3_gated_addr%0d", i), rdAddrQ[rdBase+i], firstWin[i]);
      checkVal("c3_gated_rd_en", 32'(rd_en), 32'd0);
      checkVal("c3_gated_busy", 32'(busy), 32'd1);
      pulseRows(1);
      checkVal("c3_resume_rd_en", 32'(rd_en), 32'd1);
      checkVal("c3_resume_addr", rd_addr, 32'd32);
      tick();
      pulseRows(1);
      waitDone("c3", 200);
      buildExpected(1, 4, 2, 1);
      checkStream("c3", 36, 9);

      // Backpressure: out_ready low for 10 cycles mid-map
      mark();
      applyStimulus(8'd16, 8'd2, 1'b1, 2'd1, 1'b1);
      pulseRows(3);
      for (int i = 0; i < 100 && (beatDataQ.size() - beatBase) < 10; i++) tick();
      checkVal("c4_reached_beats", 32'((beatDataQ.size() - beatBase) >= 10), 32'd1);
      out_ready = 1'b0;
      repeat (5) tick();
      checkVal("c4_stall_valid", 32'(out_valid), 32'd1);
      checkVal("c4_stall_rd_en", 32'(rd_en), 32'd0);
      repeat (5) tick();
      out_ready = 1'b1;
      waitDone("c4", 200);
      checkStream("c4", 36, 9);
      checkVal("c4_stall_stable", stallErr, 32'd0);
      checkVal("c4_outstanding", 32'(maxOutstanding <= 2), 32'd1);

      // start while busy with a different config must be ignored
      mark();
      applyStimulus(8'd16, 8'd2, 1'b1, 2'd1, 1'b1);
      pulseRows(3);
      repeat (4) tick();
      IFM_C = 8'd32; IFM_W = 8'd4; stride = 2'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      waitDone("c5", 200);
      repeat (5) tick();
      checkStream("c5", 36, 9);
      checkVal("c5_idle_busy", 32'(busy), 32'd0);

      // Reset mid-map, then a full clean map
      applyStimulus(8'd16, 8'd2, 1'b1, 2'd1, 1'b1);
      pulseRows(3);
      repeat (8) tick();
      rst_n = 1'b0;
      tick();
      checkResetOutputs("midrst");
      rst_n = 1'b1;
      tick();
      mark();
      applyStimulus(8'd16, 8'd2, 1'b1, 2'd1, 1'b1);
      pulseRows(3);
      waitDone("c6", 200);
      checkStream("c6", 36, 9);

      // Degenerate map: WP=1 < K, done two cycles after start with no reads
      mark();
      applyStimulus(8'd16, 8'd1, 1'b0, 2'd1, 1'b0);
      checkVal("c7_load_busy", 32'(busy), 32'd1);
      checkVal("c7_load_done", 32'(done), 32'd0);
      tick();
      checkVal("c7_done", 32'(done), 32'd1);
      checkVal("c7_done_busy", 32'(busy), 32'd0);
      tick();
      checkVal("c7_done_pulse", 32'(done), 32'd0);
      repeat (5) tick();
      checkVal("c7_no_reads", 32'(rdAddrQ.size() - rdBase), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/padded_ifm_reader.md
# padded_ifm_reader

Reads a padded feature map out of the line/feature buffer filled by the padding writer and streams it, one PE-wide channel word per beat, in sliding-window order (KxK, stride 1 or 2) to the next convolution stage. The block owns the read port of the buffer and gates each read on the count of padded rows the writer has completed, so reading can overlap writing. The output is a valid/ready stream with a 2-entry buffer that absorbs the fixed RAM read latency under backpressure.

## Interface
- PE, 16, channel lanes per word; data width PE*8
- K, 3, window size (square)
- ADDR_STEP, 4, address increment per buffer word (matches writer layout)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; samples config and begins a map; ignored while busy
- IFM_C  in  8  channels (multiple of PE)
- IFM_W  in  8  unpadded width = height (square map)
- padding  in  1  padding amount (0 or 1) on each side
- stride  in  2  1 or 2; other values treated as 1
- row_done  in  1  one-cycle pulse from writer per completed padded row
- rd_en  out  1  buffer read request
- rd_addr  out  32  buffer address, valid with rd_en
- rd_data  in  PE*8  read data, valid exactly 1 cycle after rd_en
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_data  out  PE*8  channel word
- out_last_win  out  1  last word of current window
- out_last  out  1  last word of map
- busy  out  1  high from cycle after start until done
- done  out  1  one-cycle pulse after last word accepted

## Operation
- Derived at LOAD (32-bit arithmetic): CW = IFM_C/PE; WP = IFM_W + 2*padding; OW = (WP-K)/stride + 1 (floor).
- Loop order, innermost first: c (0..CW-1), kx, ky (0..K-1), ox, oy (0..OW-1).
- rd_addr = (((oy*stride+ky)*WP + ox*stride+kx)*CW + c) * ADDR_STEP; implementation may compute incrementally, result must be identical.
- Row gate: rows_written counter cleared on start, +1 per row_done, saturates at WP. A read issues only if (oy*stride+ky) < rows_written. row_done in the same cycle as start counts.
- Credit rule: rd_en only when (FIFO occupancy + reads in flight) < 2; never overflow, never drop.
- FSM: IDLE -(start)-> LOAD -> READ; READ issues reads until last address issued -> DRAIN; DRAIN waits for FIFO empty and last word accepted -> IDLE with done pulse. If CW==0 or WP<K: LOAD -> IDLE with done pulse, no reads.
- out_last_win set when c=CW-1, kx=ky=K-1; out_last additionally when ox=oy=OW-1. Tags travel with the word through the FIFO.
- Reset (any time, incl. mid-map): state IDLE, counters, FIFO, rows_written cleared; in-flight read data discarded.

## Timing
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_last_win=0, out_last=0, busy=0, done=0.
- start at edge n: LOAD in cycle n+1, first rd_en earliest in cycle n+2.
- rd_en in cycle t -> rd_data in t+1 -> captured into FIFO at edge end of t+1 -> out_valid in t+2 (2-cycle read-to-output latency).
- Beat transfers when out_valid && out_ready; out_data/tags stable while out_valid && !out_ready.
- Sustained throughput 1 word/cycle with out_ready held high and rows available.
- Simultaneous FIFO push and pop in same cycle allowed at occupancy 1 or 2.
- done asserted the cycle after the out_last beat transfers; busy drops same cycle as done.

## Test plan
- IFM_C=16, IFM_W=2, padding=1, stride=1, row_done x4 before start, out_ready=1 -> 36 beats; first-window addresses 0,4,8,16,20,24,32,36,40; out_last_win on beats 9,18,27,36; out_last on beat 36; done 1 cycle later.
- IFM_C=32, IFM_W=4, padding=1, stride=2, all rows available -> 72 beats; last rd_addr=228; out_last on beat 72.
- Same as first case but only 2 row_done pulses -> exactly 6 reads (addresses 0..24), rd_en held low until third pulse, then completes normally.
- Backpressure: out_ready low 10 cycles mid-map -> out_valid held, out_data unchanged, at most 2 reads outstanding, beat sequence identical to no-stall run.
- start while busy -> ignored, sequence unaffected; rst_n low mid-map -> all outputs to reset values next cycle, new start produces full correct sequence.
- IFM_W=1, padding=0, K=3 -> no rd_en, done pulse 2 cycles after start.
